// File: rtl/wakeup_broadcaster.sv
// wakeup_broadcaster: delays issued destination tags by their latency and broadcasts them round-robin on the wakeup ports
module wakeup_broadcaster #(
    parameter int ISSUE_WIDTH      = 2,
    parameter int NUM_WAKEUP_PORTS = 2,
    parameter int PENDING_ENTRIES  = 8,
    parameter int MAX_LAT          = 7,
    localparam int LW = $clog2(MAX_LAT + 1),
    localparam int CW = $clog2(PENDING_ENTRIES + 1),
    localparam int PW = $clog2(PENDING_ENTRIES)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic [ISSUE_WIDTH-1:0]               iss_valid,
    input  logic [ISSUE_WIDTH-1:0][6:0]          iss_pdst,
    input  logic [ISSUE_WIDTH-1:0][LW-1:0]       iss_lat,
    output logic                                 iss_ready,
    output logic [NUM_WAKEUP_PORTS-1:0]          wakeup_valid,
    output logic [NUM_WAKEUP_PORTS-1:0][6:0]     wakeup_pdst,
    output logic [CW-1:0]                        pending_count
);
    logic [PENDING_ENTRIES-1:0] ent_valid;
    logic [6:0]                 ent_pdst [PENDING_ENTRIES];
    logic [LW-1:0]              ent_cnt  [PENDING_ENTRIES];
    logic [PW-1:0]              rr_ptr, rr_next;
    logic [PENDING_ENTRIES-1:0] elig, grant;
    logic [NUM_WAKEUP_PORTS-1:0] gval;
    logic [PW-1:0]              gidx [NUM_WAKEUP_PORTS];
    logic [ISSUE_WIDTH-1:0]     cap;
    logic [PW-1:0]              aidx [ISSUE_WIDTH];
    logic [CW-1:0]              nvalid;

    // occupancy and eligibility from registered state only
    always_comb begin
        nvalid = '0;
        for (int e = 0; e < PENDING_ENTRIES; e++) begin
            nvalid  = nvalid + CW'(ent_valid[e]);
            elig[e] = ent_valid[e] && ent_cnt[e] == '0;
        end
    end

    assign pending_count = nvalid;
    assign iss_ready     = (CW'(PENDING_ENTRIES) - nvalid) >= CW'(ISSUE_WIDTH);

    // round-robin scan from rr_ptr; k-th eligible entry found drives port k
    always_comb begin
        logic [PW:0]   s;
        logic [PW-1:0] idx;
        logic          done;
        grant   = '0;
        gval    = '0;
        rr_next = rr_ptr;
        for (int k = 0; k < NUM_WAKEUP_PORTS; k++) gidx[k] = '0;
        for (int j = 0; j < PENDING_ENTRIES; j++) begin
            s = {1'b0, rr_ptr} + (PW+1)'(j);
            s = s >= (PW+1)'(PENDING_ENTRIES) ? s - (PW+1)'(PENDING_ENTRIES) : s;
            idx  = s[PW-1:0];
            done = 1'b0;
            for (int k = 0; k < NUM_WAKEUP_PORTS; k++) begin
                if (elig[idx] && !done && !gval[k]) begin
                    gval[k]    = 1'b1;
                    gidx[k]    = idx;
                    grant[idx] = 1'b1;
                    rr_next    = idx == PW'(PENDING_ENTRIES - 1) ? '0 : idx + 1'b1;
                    done       = 1'b1;
                end
            end
        end
    end

    // capture qualification and lowest-free-entry allocation, lane 0 first
    always_comb begin
        logic [PENDING_ENTRIES-1:0] fr;
        logic                       found;
        fr = ~ent_valid;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            cap[i]  = iss_valid[i] && iss_ready && !flush && iss_pdst[i] != '0;
            aidx[i] = '0;
            found   = 1'b0;
            for (int e = 0; e < PENDING_ENTRIES; e++) begin
                if (cap[i] && !found && fr[e]) begin
                    aidx[i] = PW'(e);
                    fr[e]   = 1'b0;
                    found   = 1'b1;
                end
            end
        end
    end

    // table countdown, capture, grant release and registered wakeup ports
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ent_valid    <= '0;
            wakeup_valid <= '0;
            if (reset) begin
                rr_ptr      <= '0;
                wakeup_pdst <= '0;
            end
        end else begin
            for (int e = 0; e < PENDING_ENTRIES; e++) begin
                if (grant[e])
                    ent_valid[e] <= 1'b0;
                else if (ent_valid[e] && ent_cnt[e] != '0)
                    ent_cnt[e] <= ent_cnt[e] - 1'b1;
            end
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (cap[i]) begin
                    ent_valid[aidx[i]] <= 1'b1;
                    ent_pdst[aidx[i]]  <= iss_pdst[i];
                    ent_cnt[aidx[i]]   <= iss_lat[i];
                end
            end
            for (int k = 0; k < NUM_WAKEUP_PORTS; k++) begin
                wakeup_valid[k] <= gval[k];
                if (gval[k]) wakeup_pdst[k] <= ent_pdst[gidx[k]];
            end
            if (|gval) rr_ptr <= rr_next;
        end
    end
endmodule

// File: tb/tb_wakeup_broadcaster.sv
// tb_wakeup_broadcaster: directed scoreboard bench for wakeup_broadcaster
module tb_wakeup_broadcaster;
    logic            clk, reset, flush, iss_ready;
    logic [1:0]      iss_valid, wakeup_valid;
    logic [1:0][6:0] iss_pdst, wakeup_pdst;
    logic [1:0][2:0] iss_lat;
    logic [3:0]      pending_count;

    typedef struct {
        int         cyc;
        int         port;
        logic [6:0] pdst;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0, cyc = 0, c;
    bit   mon = 0;

    wakeup_broadcaster dut (
        .clk(clk), .reset(reset), .flush(flush),
        .iss_valid(iss_valid), .iss_pdst(iss_pdst), .iss_lat(iss_lat),
        .iss_ready(iss_ready), .wakeup_valid(wakeup_valid),
        .wakeup_pdst(wakeup_pdst), .pending_count(pending_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v0, input logic [6:0] p0, input logic [2:0] l0,
                       input logic v1, input logic [6:0] p1, input logic [2:0] l1);
        iss_valid = {v1, v0};
        iss_pdst  = {p1, p0};
        iss_lat   = {l1, l0};
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input int cy, input int k, input logic [6:0] p);
        exp_t e;
        e.cyc = cy; e.port = k; e.pdst = p;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mon) begin
            for (int k = 0; k < 2; k++) begin
                logic       ev;
                logic [6:0] ep;
                ev = 0; ep = 0;
                if (q.size() > 0 && q[0].cyc == cyc && q[0].port == k) begin
                    ev = 1; ep = q[0].pdst;
                    void'(q.pop_front());
                end
                chk($sformatf("wakeup_valid[%0d]@%0d", k, cyc), 32'(wakeup_valid[k]), 32'(ev));
                if (ev) chk($sformatf("wakeup_pdst[%0d]@%0d", k, cyc), 32'(wakeup_pdst[k]), 32'(ep));
            end
            while (q.size() > 0 && q[0].cyc <= cyc) void'(q.pop_front());
        end
    endtask

    task automatic do_reset();
        mon   = 0;
        reset = 1;
        flush = 0;
        for (int i = 0; i < 2; i++) begin
            iss_valid = 2'($urandom);
            iss_pdst  = 14'($urandom);
            iss_lat   = 6'($urandom);
            tick();
        end
        reset = 0;
        idle();
        mon = 1;
    endtask

    initial begin
        idle();
        // reset with random issue traffic
        do_reset();
        chk("rst_wakeup_valid", 32'(wakeup_valid), 0);
        chk("rst_wakeup_pdst", 32'(wakeup_pdst), 0);
        chk("rst_iss_ready", 32'(iss_ready), 1);
        chk("rst_pending_count", 32'(pending_count), 0);

        // contention from a fresh rr_ptr
        c = cyc;
        push(c + 3, 0, 10); push(c + 3, 1, 11);
        push(c + 4, 0, 12); push(c + 4, 1, 13);
        drv(1, 10, 1, 1, 11, 1); tick();
        drv(1, 12, 0, 1, 13, 0); tick();
        idle();
        chk("cont_count_c2", 32'(pending_count), 4);
        tick(); tick(); tick();
        chk("cont_count_c5", 32'(pending_count), 0);

        // single op, lat 0 then lat 3
        c = cyc;
        push(c + 2, 0, 5);
        drv(1, 5, 0, 0, 0, 0); tick(); idle();
        chk("single_count", 32'(pending_count), 1);
        repeat (4) tick();
        c = cyc;
        push(c + 5, 0, 5);
        drv(1, 5, 3, 0, 0, 0); tick(); idle();
        repeat (7) tick();
        chk("single_count_end", 32'(pending_count), 0);

        // fill the table at max latency
        do_reset();
        c = cyc;
        for (int j = 0; j < 10; j++) begin
            chk($sformatf("full_ready_j%0d", j), 32'(iss_ready), (j < 4 || j == 9) ? 1 : 0);
            chk($sformatf("full_count_j%0d", j), 32'(pending_count), j < 4 ? 2 * j : (j < 9 ? 8 : 6));
            if (j < 9) drv(1, 7'(20 + 2 * j), 7, 1, 7'(21 + 2 * j), 7);
            else idle();
            if (j < 4) begin
                push(c + j + 9, 0, 7'(20 + 2 * j));
                push(c + j + 9, 1, 7'(21 + 2 * j));
            end
            tick();
        end
        idle();
        repeat (5) tick();
        chk("full_count_end", 32'(pending_count), 0);

        // flush with 6 pending and a same-cycle issue
        for (int j = 0; j < 3; j++) begin
            drv(1, 7'(60 + 2 * j), 7, 1, 7'(61 + 2 * j), 7);
            tick();
        end
        chk("flush_count_f", 32'(pending_count), 6);
        chk("flush_ready_f", 32'(iss_ready), 1);
        drv(1, 70, 0, 1, 71, 0);
        flush = 1;
        tick();
        flush = 0;
        idle();
        chk("flush_count_f1", 32'(pending_count), 0);
        repeat (12) tick();
        chk("flush_count_end", 32'(pending_count), 0);

        // tag zero is dropped, duplicate tag broadcasts twice
        c = cyc;
        push(c + 2, 0, 9); push(c + 3, 0, 9);
        drv(1, 0, 0, 1, 9, 0); tick();
        chk("dup_count_c1", 32'(pending_count), 1);
        drv(1, 9, 0, 0, 0, 0); tick(); idle();
        chk("dup_count_c2", 32'(pending_count), 1);
        tick();
        chk("dup_count_c3", 32'(pending_count), 0);
        repeat (3) tick();

        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
